// File: rtl/control_config_campos.sv
// Turns debounced switches/buttons into configuration commands: mode select,
// field index, inc/dec pulses with auto-repeat, and commit strobe.
module control_config_campos #(
  parameter int unsigned REPEAT_DELAY_CYC = 50_000_000,
  parameter int unsigned REPEAT_RATE_CYC  = 10_000_000,
  parameter int unsigned NUM_CAMPOS       = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sw_db,
  input  logic [4:0] btn_db,
  output logic [1:0] modo,
  output logic [1:0] campo,
  output logic       inc_pulse,
  output logic       dec_pulse,
  output logic       escribir,
  output logic       formato_12h
);

  localparam int unsigned MAX_CYC = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ?
                                    REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(REPEAT_DELAY_CYC - 1);
  localparam logic [CNT_W-1:0] RATE_LOAD  = CNT_W'(REPEAT_RATE_CYC - 1);
  localparam logic [1:0]       CAMPO_LAST = 2'(NUM_CAMPOS - 1);

  localparam logic [1:0] M_NORMAL    = 2'b00;
  localparam logic [1:0] M_CFG_HORA  = 2'b01;
  localparam logic [1:0] M_CFG_FECHA = 2'b10;
  localparam logic [1:0] M_CFG_TIMER = 2'b11;

  localparam logic [1:0] R_IDLE  = 2'b00;
  localparam logic [1:0] R_DELAY = 2'b01;
  localparam logic [1:0] R_RATE  = 2'b10;

  logic [1:0]       mode_q, mode_d;
  logic [1:0]       campo_q, campo_d;
  logic [1:0]       rep_q, rep_d;
  logic             dir_q, dir_d;      // 0 = UP, 1 = DOWN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             inc_q, inc_d;
  logic             dec_q, dec_d;
  logic             wr_q, wr_d;
  logic [4:0]       btn_q;
  logic             fmt_q;

  logic [4:0] rise;
  logic       in_cfg;
  logic       held;

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q  <= M_NORMAL;
      campo_q <= 2'b00;
      rep_q   <= R_IDLE;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
      wr_q    <= 1'b0;
      btn_q   <= 5'b00000;
      fmt_q   <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      campo_q <= campo_d;
      rep_q   <= rep_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
      wr_q    <= wr_d;
      btn_q   <= btn_db;
      fmt_q   <= sw_db[3];
    end
  end

  // Next-state: mode priority, field navigation, UP/DOWN repeat
  always_comb begin
    mode_d  = M_NORMAL;
    campo_d = campo_q;
    rep_d   = rep_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    inc_d   = 1'b0;
    dec_d   = 1'b0;
    wr_d    = 1'b0;
    rise    = btn_db & ~btn_q;
    in_cfg  = (mode_q != M_NORMAL);
    held    = dir_q ? (btn_db[1] && !btn_db[0]) : (btn_db[0] && !btn_db[1]);

    if (sw_db[0])      mode_d = M_CFG_HORA;
    else if (sw_db[1]) mode_d = M_CFG_FECHA;
    else if (sw_db[2]) mode_d = M_CFG_TIMER;

    if (in_cfg && (mode_d != mode_q)) begin
      // Leaving a config mode commits and drops any edit/repeat in progress
      wr_d    = 1'b1;
      campo_d = 2'b00;
      rep_d   = R_IDLE;
      cnt_d   = '0;
    end else if (!in_cfg) begin
      if (mode_d != M_NORMAL) campo_d = 2'b00;
    end else begin
      if (rise[4]) begin
        wr_d    = 1'b1;
        campo_d = 2'b00;
      end else if (rise[3] && !rise[2]) begin
        campo_d = (campo_q == CAMPO_LAST) ? 2'b00 : campo_q + 2'd1;
      end else if (rise[2] && !rise[3]) begin
        campo_d = (campo_q == 2'b00) ? CAMPO_LAST : campo_q - 2'd1;
      end

      case (rep_q)
        R_IDLE: begin
          if (rise[0] && !btn_db[1]) begin
            inc_d = 1'b1;
            dir_d = 1'b0;
            cnt_d = DELAY_LOAD;
            rep_d = R_DELAY;
          end else if (rise[1] && !btn_db[0]) begin
            dec_d = 1'b1;
            dir_d = 1'b1;
            cnt_d = DELAY_LOAD;
            rep_d = R_DELAY;
          end
        end
        R_DELAY, R_RATE: begin
          if (!held) begin
            rep_d = R_IDLE;
            cnt_d = '0;
          end else if (cnt_q == '0) begin
            inc_d = !dir_q;
            dec_d = dir_q;
            cnt_d = RATE_LOAD;
            rep_d = R_RATE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          rep_d = R_IDLE;
          cnt_d = '0;
        end
      endcase
    end
  end

  assign modo        = mode_q;
  assign campo       = campo_q;
  assign inc_pulse   = inc_q;
  assign dec_pulse   = dec_q;
  assign escribir    = wr_q;
  assign formato_12h = fmt_q;

endmodule

// File: tb/tb_control_config_campos.sv
// Self-checking bench: directed scenarios plus random switch/button activity
// compared every cycle against a press-age based reference model.
module tb_control_config_campos;

  localparam int unsigned D  = 20;
  localparam int unsigned R  = 5;
  localparam int unsigned NC = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sw_db;
  logic [4:0] btn_db;
  logic [1:0] modo, campo;
  logic       inc_pulse, dec_pulse, escribir, formato_12h;

  control_config_campos #(
    .REPEAT_DELAY_CYC(D),
    .REPEAT_RATE_CYC (R),
    .NUM_CAMPOS      (NC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sw_db      (sw_db),
    .btn_db     (btn_db),
    .modo       (modo),
    .campo      (campo),
    .inc_pulse  (inc_pulse),
    .dec_pulse  (dec_pulse),
    .escribir   (escribir),
    .formato_12h(formato_12h)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  // Reference model: a press is tracked by its age in cycles
  int         m_mode, m_campo, m_active, m_dir, m_age;
  logic [4:0] m_prev;
  int         e_inc, e_dec, e_wr, e_fmt;

  function automatic int prio(input logic [3:0] s);
    if (s[0]) return 1;
    if (s[1]) return 2;
    if (s[2]) return 3;
    return 0;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_campo = 0; m_active = 0; m_dir = 0; m_age = 0; m_prev = 5'b0;
    e_inc = 0; e_dec = 0; e_wr = 0; e_fmt = 0;
  endtask

  task automatic model_step();
    int         nm;
    logic [4:0] rs;
    logic       up, dn;
    if (!reset) begin
      model_reset();
      return;
    end
    nm = prio(sw_db);
    rs = btn_db & ~m_prev;
    up = btn_db[0];
    dn = btn_db[1];
    e_inc = 0; e_dec = 0; e_wr = 0;
    if (m_mode != 0 && nm != m_mode) begin
      e_wr = 1; m_campo = 0; m_active = 0;
    end else if (m_mode == 0) begin
      if (nm != 0) m_campo = 0;
    end else begin
      if (rs[4]) begin
        e_wr = 1; m_campo = 0;
      end else if (rs[3] && !rs[2]) m_campo = (m_campo + 1) % NC;
      else if (rs[2] && !rs[3]) m_campo = (m_campo + NC - 1) % NC;
      if (m_active != 0) begin
        m_age++;
        if (!(m_dir ? (dn && !up) : (up && !dn))) m_active = 0;
        else if (m_age == D || (m_age > D && (m_age - D) % R == 0)) begin
          if (m_dir != 0) e_dec = 1; else e_inc = 1;
        end
      end else if (rs[0] && !dn) begin
        m_active = 1; m_dir = 0; m_age = 0; e_inc = 1;
      end else if (rs[1] && !up) begin
        m_active = 1; m_dir = 1; m_age = 0; e_dec = 1;
      end
    end
    m_mode = nm;
    m_prev = btn_db;
    e_fmt  = sw_db[3];
  endtask

  task automatic check_all();
    check("modo",        32'(modo),        32'(m_mode));
    check("campo",       32'(campo),       32'(m_campo));
    check("inc_pulse",   32'(inc_pulse),   32'(e_inc));
    check("dec_pulse",   32'(dec_pulse),   32'(e_dec));
    check("escribir",    32'(escribir),    32'(e_wr));
    check("formato_12h", 32'(formato_12h), 32'(e_fmt));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  int got_cyc[$];
  int exp_cyc[5] = '{1, 21, 26, 31, 36};
  int n_inc, n_dec;

  initial begin
    reset  = 1'b0;
    sw_db  = 4'b0000;
    btn_db = 5'b00000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset = 1'b1;

    // Plan 1: enter CFG_HORA
    sw_db = 4'b0001;
    step();
    check("p1_modo", 32'(modo), 32'd1);
    check("p1_escribir", 32'(escribir), 32'd0);

    // Plan 2: RIGHT x3 then LEFT
    for (int k = 0; k < 4; k++) begin
      btn_db = (k < 3) ? 5'b01000 : 5'b00100;
      step();
      check("p2_campo", 32'(campo), (k == 0) ? 32'd1 : (k == 1) ? 32'd2 : (k == 2) ? 32'd0 : 32'd2);
      btn_db = 5'b00000;
      step();
    end

    // Plan 3: hold UP for 40 cycles
    btn_db = 5'b00001;
    n_dec = 0;
    got_cyc.delete();
    for (int i = 1; i <= 40; i++) begin
      step();
      if (inc_pulse) got_cyc.push_back(i);
      if (dec_pulse) n_dec++;
    end
    check("p3_npulses", 32'(got_cyc.size()), 32'd5);
    for (int k = 0; k < 5; k++)
      check("p3_pulse_cycle", (k < got_cyc.size()) ? 32'(got_cyc[k]) : 32'hFFFF_FFFF, 32'(exp_cyc[k]));
    check("p3_no_dec", 32'(n_dec), 32'd0);
    btn_db = 5'b00000;
    step();

    // Plan 4: UP held, DOWN joins, DOWN released
    btn_db = 5'b00001;
    repeat (9) step();
    n_inc = 0; n_dec = 0;
    btn_db = 5'b00011;
    for (int i = 0; i < 30; i++) begin
      if (i == 5) btn_db = 5'b00001;
      step();
      n_inc += int'(inc_pulse);
      n_dec += int'(dec_pulse);
    end
    check("p4_no_inc", 32'(n_inc), 32'd0);
    check("p4_no_dec", 32'(n_dec), 32'd0);
    btn_db = 5'b00000;
    step();
    btn_db = 5'b00001;
    step();
    check("p4_repress", 32'(inc_pulse), 32'd1);
    btn_db = 5'b00000;
    step();

    // Plan 5: CFG_FECHA campo=2, then HORA, then NORMAL
    sw_db = 4'b0010;
    step();
    for (int k = 0; k < 2; k++) begin
      btn_db = 5'b01000; step();
      btn_db = 5'b00000; step();
    end
    check("p5_campo2", 32'(campo), 32'd2);
    sw_db = 4'b0011;
    step();
    check("p5_modo_hora", 32'(modo), 32'd1);
    check("p5_wr_switch", 32'(escribir), 32'd1);
    check("p5_campo0", 32'(campo), 32'd0);
    step();
    check("p5_wr_once", 32'(escribir), 32'd0);
    sw_db = 4'b0000;
    step();
    check("p5_modo_normal", 32'(modo), 32'd0);
    check("p5_wr_leave", 32'(escribir), 32'd1);

    // Plan 6: DOWN held in CFG_TIMER across a reset
    sw_db = 4'b1100;
    step();
    check("p6_fmt", 32'(formato_12h), 32'd1);
    btn_db = 5'b00010;
    step();
    check("p6_dec_first", 32'(dec_pulse), 32'd1);
    repeat (5) step();
    reset = 1'b0;
    model_reset();
    #1;
    check_all();
    check("p6_rst_modo", 32'(modo), 32'd0);
    check("p6_rst_fmt", 32'(formato_12h), 32'd0);
    repeat (3) step();
    reset = 1'b1;
    n_dec = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      n_dec += int'(dec_pulse);
    end
    check("p6_no_dec_after_rst", 32'(n_dec), 32'd0);
    check("p6_modo_timer", 32'(modo), 32'd3);
    sw_db = 4'b0100;
    step();
    check("p6_fmt_lag", 32'(formato_12h), 32'd0);
    btn_db = 5'b00000;
    step();
    btn_db = 5'b00010;
    step();
    check("p6_dec_repress", 32'(dec_pulse), 32'd1);

    // Random phase
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 59) == 0) sw_db = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) btn_db = btn_db ^ 5'(1 << $urandom_range(0, 4));
      if ($urandom_range(0, 3) == 0) btn_db[4:2] = 3'b000;
      if ($urandom_range(0, 1499) == 0) begin
        reset = 1'b0;
        model_reset();
        #1;
        check_all();
        repeat (2) step();
        reset = 1'b1;
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
